// File: rtl/btime_dn_ctrl_if.sv
// Bus bundle between the ROM download source and btime_dn_ctrl.
// Checksum signals exist only when BTIME_DN_CHECKSUM_EN is defined.
interface btime_dn_ctrl_if;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ext_reset;
  logic        tgt_ready;
  logic [16:0] dn_addr;
  logic [7:0]  dn_data;
  logic [3:0]  dn_we;
  logic        core_reset;
  logic        dn_done;
  logic        overrun;
  logic        range_err;
`ifdef BTIME_DN_CHECKSUM_EN
  logic [7:0]  exp_sum;
  logic [7:0]  sum;
  logic        sum_err;

  modport master (
    output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ext_reset, tgt_ready, exp_sum,
    input  dn_addr, dn_data, dn_we, core_reset, dn_done, overrun, range_err, sum, sum_err
  );
  modport slave (
    input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ext_reset, tgt_ready, exp_sum,
    output dn_addr, dn_data, dn_we, core_reset, dn_done, overrun, range_err, sum, sum_err
  );
`else
  modport master (
    output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ext_reset, tgt_ready,
    input  dn_addr, dn_data, dn_we, core_reset, dn_done, overrun, range_err
  );
  modport slave (
    input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ext_reset, tgt_ready,
    output dn_addr, dn_data, dn_we, core_reset, dn_done, overrun, range_err
  );
`endif
endinterface

// File: rtl/btime_dn_ctrl.sv
// ROM download controller: buffers ioctl bytes into four target regions and sequences core reset.
// Optional BTIME_DN_CHECKSUM_EN adds a running byte sum compared against exp_sum during HOLD.
module btime_dn_ctrl #(
  parameter logic [16:0] REG1_BASE   = 17'h0C000,
  parameter logic [16:0] REG2_BASE   = 17'h0E000,
  parameter logic [16:0] REG3_BASE   = 17'h16000,
  parameter logic [16:0] ROM_SIZE    = 17'h1A000,
  parameter int unsigned HOLD_CYCLES = 16
) (
  input  logic            clk_sys,
  input  logic            reset,
  btime_dn_ctrl_if.slave  bus
);

  localparam logic [2:0] StWait  = 3'd0;
  localparam logic [2:0] StLoad  = 3'd1;
  localparam logic [2:0] StDrain = 3'd2;
  localparam logic [2:0] StHold  = 3'd3;
  localparam logic [2:0] StRun   = 3'd4;

  localparam logic [7:0] HoldLast = 8'(HOLD_CYCLES - 1);

  logic [2:0]  state_q, state_d;
  logic        buf_full_q, buf_full_d;
  logic [16:0] buf_addr_q, buf_addr_d;
  logic [7:0]  buf_data_q, buf_data_d;
  logic [1:0]  buf_rgn_q, buf_rgn_d;
  logic [7:0]  hold_cnt_q, hold_cnt_d;
  logic        core_reset_q, core_reset_d;
  logic        dn_done_q, dn_done_d;
  logic        overrun_q, overrun_d;
  logic        range_err_q, range_err_d;

  logic        addr_ok, wr_load, drain, accept, clear_flags;
  logic [1:0]  rgn;
  logic [16:0] local_addr;
  logic [3:0]  dn_we_c;

  always_comb begin
    addr_ok = (bus.ioctl_addr[24:17] == 8'd0) && (bus.ioctl_addr[16:0] < ROM_SIZE);
    if (bus.ioctl_addr[16:0] < REG1_BASE) begin
      rgn        = 2'd0;
      local_addr = bus.ioctl_addr[16:0];
    end else if (bus.ioctl_addr[16:0] < REG2_BASE) begin
      rgn        = 2'd1;
      local_addr = bus.ioctl_addr[16:0] - REG1_BASE;
    end else if (bus.ioctl_addr[16:0] < REG3_BASE) begin
      rgn        = 2'd2;
      local_addr = bus.ioctl_addr[16:0] - REG2_BASE;
    end else begin
      rgn        = 2'd3;
      local_addr = bus.ioctl_addr[16:0] - REG3_BASE;
    end
  end

  // A drain and a new write in the same cycle hand the buffer straight over.
  assign wr_load = (state_q == StLoad) && bus.ioctl_wr;
  assign drain   = buf_full_q && bus.tgt_ready;
  assign accept  = wr_load && addr_ok && (!buf_full_q || drain);

  always_comb begin
    buf_full_d = buf_full_q;
    buf_addr_d = buf_addr_q;
    buf_data_d = buf_data_q;
    buf_rgn_d  = buf_rgn_q;
    if (accept) begin
      buf_full_d = 1'b1;
      buf_addr_d = local_addr;
      buf_data_d = bus.ioctl_dout;
      buf_rgn_d  = rgn;
    end else if (drain) begin
      buf_full_d = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StWait:  if (bus.ioctl_download) state_d = StLoad;
      StLoad:  if (!bus.ioctl_download) state_d = StDrain;
      StDrain: begin
        if (bus.ioctl_download) state_d = StLoad;
        else if (!buf_full_d)   state_d = StHold;
      end
      StHold: begin
        if (bus.ioctl_download)         state_d = StLoad;
        else if (hold_cnt_q == HoldLast) state_d = StRun;
      end
      StRun:   if (bus.ioctl_download) state_d = StLoad;
      default: state_d = StWait;
    endcase
  end

  assign clear_flags = (state_q == StRun) && (state_d == StLoad);

  always_comb begin
    hold_cnt_d   = ((state_q == StHold) && (state_d == StHold)) ? hold_cnt_q + 8'd1 : 8'd0;
    dn_done_d    = (state_q == StHold) && (state_d == StRun);
    // Only a settled RUN lets ext_reset through, so core_reset stays high on entry and exit.
    core_reset_d = ((state_q == StRun) && (state_d == StRun)) ? bus.ext_reset : 1'b1;
    overrun_d    = clear_flags ? 1'b0 :
                   (overrun_q || (wr_load && addr_ok && buf_full_q && !drain));
    range_err_d  = clear_flags ? 1'b0 : (range_err_q || (wr_load && !addr_ok));
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q      <= StWait;
      buf_full_q   <= 1'b0;
      buf_addr_q   <= '0;
      buf_data_q   <= '0;
      buf_rgn_q    <= '0;
      hold_cnt_q   <= '0;
      core_reset_q <= 1'b1;
      dn_done_q    <= 1'b0;
      overrun_q    <= 1'b0;
      range_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      buf_full_q   <= buf_full_d;
      buf_addr_q   <= buf_addr_d;
      buf_data_q   <= buf_data_d;
      buf_rgn_q    <= buf_rgn_d;
      hold_cnt_q   <= hold_cnt_d;
      core_reset_q <= core_reset_d;
      dn_done_q    <= dn_done_d;
      overrun_q    <= overrun_d;
      range_err_q  <= range_err_d;
    end
  end

  // Gated by reset so a byte caught by reset is never written.
  always_comb begin
    dn_we_c = 4'b0000;
    if (drain && !reset) dn_we_c[buf_rgn_q] = 1'b1;
  end

  assign bus.dn_we      = dn_we_c;
  assign bus.dn_addr    = buf_addr_q;
  assign bus.dn_data    = buf_data_q;
  assign bus.core_reset = core_reset_q;
  assign bus.dn_done    = dn_done_q;
  assign bus.overrun    = overrun_q;
  assign bus.range_err  = range_err_q;

`ifdef BTIME_DN_CHECKSUM_EN
  logic [7:0] sum_q, sum_d;
  logic       sum_err_q, sum_err_d;

  always_comb begin
    sum_d = sum_q;
    if ((state_q != StLoad) && (state_d == StLoad)) sum_d = 8'd0;
    else if (accept)                                 sum_d = sum_q + bus.ioctl_dout;
    sum_err_d = clear_flags ? 1'b0 :
                (sum_err_q || ((state_q == StHold) && (sum_q != bus.exp_sum)));
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      sum_q     <= 8'd0;
      sum_err_q <= 1'b0;
    end else begin
      sum_q     <= sum_d;
      sum_err_q <= sum_err_d;
    end
  end

  assign bus.sum     = sum_q;
  assign bus.sum_err = sum_err_q;
`endif

endmodule
